led_bank_arbiter: RTL and testbench
===================================

# led_bank_arbiter

Shares one bank of board LEDs between several pattern sources, such as the LED flasher, a switch-mirror display and an error indicator. Requesters use a level req/gnt handshake. A round-robin arbiter with a minimum ownership time, measured in prescaled ticks, selects the owner. The selected requester's pattern is registered onto `outLED`. The block sits between the pattern generators and the top-level LED pins and replaces direct pin assignment.

## Interface
- `N`, 8: LED bank width.
- `NREQ`, 3: number of requesters (≥2).
- `DIV_BUS`, 32: width of the tick prescaler counter.
- `DIVIDER`, 2: clk cycles per tick. Use 2 for simulation; 50 000 000 gives 1 Hz at 50 MHz.
- `MIN_HOLD`, 4: ticks an owner keeps the bank before it can be preempted (≥1).

- `clk`, in, 1: system clock; all logic on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, NREQ: level request, one bit per requester.
- `pat`, in, NREQ*N: requester k's pattern is `pat[k*N +: N]`.
- `gnt`, out, NREQ: one-hot grant, or all zero.
- `outLED`, out, N: registered LED drive.
- `busy`, out, 1: high while any requester owns the bank.
- `tick`, out, 1: one-cycle prescaler pulse.

## Operation
- **Prescaler:** counts 0..DIVIDER-1 and wraps. `tick`=1 in the cycle the count equals DIVIDER-1. It is free-running from reset and is a clock enable only; the block generates no derived clock.
- **Round-robin pointer `ptr`:** resets to 0. Search order is ptr, ptr+1, … mod NREQ. On release of owner g, `ptr` becomes (g+1) mod NREQ.
- **States:**
  - IDLE: `gnt`=0, `outLED`=0, `busy`=0. If `req`≠0, pick the winner w by the search order. Next cycle: OWN, `gnt`=onehot(w), `outLED`=`pat[w]`, hold counter=0.
  - OWN(g): every cycle, `outLED` <= `pat[g]`. The hold counter increments on `tick` and saturates at MIN_HOLD.
    - `req[g]`=0: go to GAP next cycle, regardless of the hold count.
    - Otherwise, hold count == MIN_HOLD and `req` has another bit set: go to GAP.
    - Otherwise, stay in OWN.
  - GAP: lasts exactly 1 cycle. `gnt`=0, `outLED`=0, `busy`=0, `ptr` updated. Then IDLE.
- The owner may change `pat[g]` freely; there is no per-pattern handshake.
- A requester that drops `req` in the same cycle it would have been granted is not granted; arbitration uses the sampled `req`.
- After GAP, a sole requester may be re-granted. This costs 2 blank cycles (GAP + IDLE).
- **Reset, including mid-ownership:** next edge gives IDLE, `gnt`=0, `outLED`=0, `busy`=0, `tick`=0, `ptr`=0, and hold and prescaler counters at 0.

## Timing
- Grant latency: `req` sampled in IDLE at edge t gives `gnt`/`outLED`/`busy` valid after edge t+1.
- Pattern latency while owning: 1 cycle from `pat` to `outLED`.
- Release latency: condition true at edge t gives GAP after t+1 and a new grant earliest after t+3.
- Minimum contended ownership: MIN_HOLD ticks, with the first tick counted being the first `tick` after grant. At defaults this is 8–9 clk cycles.
- `gnt`, `outLED` and `busy` are all registered outputs; there are no combinational paths from inputs.

## Configuration
- `LED_ARB_PRIORITY_EN` defined:
  - Requester 0 is high priority. In IDLE it wins whenever `req[0]`=1, ignoring `ptr`.
  - In OWN(g≠0), `req[0]`=1 forces GAP next cycle, ignoring MIN_HOLD.
  - Requester 0 itself is preempted only by its own release; MIN_HOLD does not apply to it.
  - After requester 0 releases, `ptr` becomes 1.
- Undefined: pure round-robin as above. Requester 0 is an ordinary requester.

## Test plan
Defaults: N=8, NREQ=3, DIVIDER=2, MIN_HOLD=4.
- **Reset:** `rst`=1 for 2 cycles with `req`=3'b111 → `gnt`=000, `outLED`=8'h00, `busy`=0, `tick`=0. Then deassert `rst`; `gnt`=001 one cycle after the first sampled edge.
- **Single request:** `req`=010, `pat[1]`=8'hA5 → `gnt`=010, `outLED`=A5 one cycle later. Change `pat[1]` to 8'h3C → `outLED`=3C next cycle.
- **Contention:** `req`=111 from IDLE → `gnt`=001 until 4 ticks have elapsed, then 1 cycle of `gnt`=000/`outLED`=00. Then IDLE, then `gnt`=010, then later 100, then 001 (rotation).
- **Early release:** owner 2 drops `req[2]` 2 cycles after grant while `req[0]` is pending → GAP next cycle, then `gnt`=001. No wait for MIN_HOLD.
- **Priority:** owner 2 holds, `req[0]` rises 1 cycle after grant → with `LED_ARB_PRIORITY_EN`, GAP next cycle, then `gnt`=001. Without it, `gnt`=100 is held until 4 ticks have elapsed.
- **Mid-ownership reset:** `rst`=1 while `gnt`=010 and `outLED`=A5 → next edge gives all outputs 0 and `ptr`=0. With `req`=111 after release, `gnt`=001.

Source files
------------

// File: rtl/led_bank_if.sv
// rtl/led_bank_if.sv - request/pattern/grant bundle between pattern sources and the LED arbiter
//
// Purpose : groups the requester handshake, the pattern bus and the LED-side
//           status outputs of led_bank_arbiter into one interface.
// Signals : req    - level request, one bit per requester
//           pat    - packed patterns, requester k at pat[k*N +: N]
//           gnt    - one-hot grant or all zero
//           outLED - registered LED drive
//           busy   - a requester currently owns the bank
//           tick   - one-cycle prescaler pulse
// Modports: master - the pattern sources (drive req/pat)
//           slave  - the arbiter (drives gnt/outLED/busy/tick)
interface led_bank_if #(
  parameter int N    = 8,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] pat;
  logic [NREQ-1:0]   gnt;
  logic [N-1:0]      outLED;
  logic              busy;
  logic              tick;

  modport master (output req, pat, input gnt, outLED, busy, tick);
  modport slave  (input req, pat, output gnt, outLED, busy, tick);
endinterface

// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin LED bank arbiter with minimum ownership time
//
// Purpose : shares one LED bank between NREQ pattern sources. A round-robin
//           arbiter with a minimum hold time (counted in prescaled ticks)
//           picks the owner; the owner's pattern is registered onto outLED.
//           Every ownership ends with a one-cycle blank GAP before IDLE.
// Ports   : clk - system clock, rising edge
//           rst - synchronous active-high reset
//           bus - led_bank_if.slave (req, pat in; gnt, outLED, busy, tick out)
// Option  : LED_ARB_PRIORITY_EN - requester 0 becomes high priority: it wins
//           in IDLE, preempts any other owner immediately, and is never
//           subject to MIN_HOLD itself.
module led_bank_arbiter #(
  parameter int N        = 8,
  parameter int NREQ     = 3,
  parameter int DIV_BUS  = 32,
  parameter int DIVIDER  = 2,
  parameter int MIN_HOLD = 4
) (
  input  logic      clk,
  input  logic      rst,
  led_bank_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MIN_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     ptr, ptr_nx;
  logic [IW-1:0]     own, own_nx;
  logic [HW-1:0]     hold, hold_nx;
  logic [NREQ-1:0]   gnt_q, gnt_nx;
  logic [N-1:0]      led_q, led_nx;
  logic              busy_q, busy_nx;
  logic [DIV_BUS-1:0] div_cnt;
  logic              tick;

  logic [IW-1:0]     win;
  logic              win_found;
  logic [IW:0]       sum;
  logic              others;
  logic              rel_rr;
  logic              rel;

  // Free-running prescaler; tick is only a clock enable.
  always_ff @(posedge clk) begin
    if (rst || div_cnt == DIV_BUS'(DIVIDER - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_BUS'(DIVIDER - 1));

  // Search from ptr upwards, wrapping modulo NREQ.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    sum       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ))
        sum = sum - (IW+1)'(NREQ);
      if (!win_found && bus.req[sum[IW-1:0]]) begin
        win       = sum[IW-1:0];
        win_found = 1'b1;
      end
    end
`ifdef LED_ARB_PRIORITY_EN
    if (bus.req[0]) begin
      win       = '0;
      win_found = 1'b1;
    end
`endif
  end

  // gnt_q is onehot(own) while owning, so masking with it leaves the others.
  assign others = |(bus.req & ~gnt_q);
  assign rel_rr = !bus.req[own] || (hold == HW'(MIN_HOLD) && others);

`ifdef LED_ARB_PRIORITY_EN
  assign rel = (own == '0) ? !bus.req[0] : (rel_rr || bus.req[0]);
`else
  assign rel = rel_rr;
`endif

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    own_nx   = own;
    hold_nx  = hold;
    gnt_nx   = gnt_q;
    led_nx   = led_q;
    busy_nx  = busy_q;
    case (state)
      S_IDLE: begin
        gnt_nx  = '0;
        led_nx  = '0;
        busy_nx = 1'b0;
        hold_nx = '0;
        if (win_found) begin
          state_nx = S_OWN;
          own_nx   = win;
          gnt_nx   = NREQ'(1) << win;
          led_nx   = bus.pat[int'(win)*N +: N];
          busy_nx  = 1'b1;
        end
      end
      S_OWN: begin
        if (rel) begin
          state_nx = S_GAP;
          gnt_nx   = '0;
          led_nx   = '0;
          busy_nx  = 1'b0;
          ptr_nx   = (own == IW'(NREQ - 1)) ? '0 : own + 1'b1;
        end else begin
          led_nx = bus.pat[int'(own)*N +: N];
          if (tick && hold != HW'(MIN_HOLD))
            hold_nx = hold + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        gnt_nx   = '0;
        led_nx   = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      own    <= '0;
      hold   <= '0;
      gnt_q  <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      own    <= own_nx;
      hold   <= hold_nx;
      gnt_q  <= gnt_nx;
      led_q  <= led_nx;
      busy_q <= busy_nx;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.outLED = led_q;
  assign bus.busy   = busy_q;
  assign bus.tick   = tick;
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - directed self-checking bench for led_bank_arbiter
module tb_led_bank_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  led_bank_if #(.N(8), .NREQ(3)) bus ();

  led_bank_arbiter #(
    .N(8), .NREQ(3), .DIV_BUS(32), .DIVIDER(2), .MIN_HOLD(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [2:0] g, input logic [7:0] led, input logic b);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
    check({tag, "_led"}, 32'(bus.outLED), 32'(led));
    check({tag, "_busy"}, 32'(bus.busy), 32'(b));
  endtask

  // Owner just granted (already checked); expect it held for `more` further
  // cycles, then GAP and IDLE blanks.
  task automatic hold_then_gap(input string tag, input logic [2:0] g, input logic [7:0] led,
                               input int more, input bit chk_tick);
    for (int i = 0; i < more; i++) begin
      step(1);
      chk_out({tag, "_hold"}, g, led, 1'b1);
      if (chk_tick) check({tag, "_tick"}, 32'(bus.tick), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    step(1);
    chk_out({tag, "_gap"}, 3'b000, 8'h00, 1'b0);
    step(1);
    chk_out({tag, "_idle"}, 3'b000, 8'h00, 1'b0);
  endtask

  initial begin
    bus.req = 3'b111;
    bus.pat = {8'hC3, 8'hA5, 8'h11};
    rst = 1'b1;
    @(negedge clk);
    step(2);
    chk_out("reset", 3'b000, 8'h00, 1'b0);
    check("reset_tick", 32'(bus.tick), 32'd0);

    // Contention and rotation: 0 -> 1 -> 2 -> 0
    rst = 1'b0;
    step(1);
    chk_out("rr0", 3'b001, 8'h11, 1'b1);
    check("rr0_tick", 32'(bus.tick), 32'd1);
    hold_then_gap("rr0", 3'b001, 8'h11, 7, 1'b1);
    step(1);
    chk_out("rr1", 3'b010, 8'hA5, 1'b1);
    hold_then_gap("rr1", 3'b010, 8'hA5, 7, 1'b0);
    step(1);
    chk_out("rr2", 3'b100, 8'hC3, 1'b1);
    hold_then_gap("rr2", 3'b100, 8'hC3, 7, 1'b0);
    step(1);
    chk_out("rr3", 3'b001, 8'h11, 1'b1);

    // Owner 0 releases; sole requester 1 granted after GAP + IDLE
    bus.req = 3'b010;
    step(1);
    chk_out("rel0_gap", 3'b000, 8'h00, 1'b0);
    step(1);
    chk_out("rel0_idle", 3'b000, 8'h00, 1'b0);
    step(1);
    chk_out("single", 3'b010, 8'hA5, 1'b1);
    bus.pat[15:8] = 8'h3C;
    step(1);
    chk_out("single_pat", 3'b010, 8'h3C, 1'b1);
    bus.pat[15:8] = 8'hA5;
    step(1);
    chk_out("single_pat2", 3'b010, 8'hA5, 1'b1);

    // Mid-ownership reset (ptr is 1 here); afterwards 111 must grant 0
    rst = 1'b1;
    bus.req = 3'b111;
    step(1);
    chk_out("midrst", 3'b000, 8'h00, 1'b0);
    check("midrst_tick", 32'(bus.tick), 32'd0);
    rst = 1'b0;
    step(1);
    chk_out("midrst_regrant", 3'b001, 8'h11, 1'b1);

    // Early release of owner 2 while req[0] pending
    rst = 1'b1;
    bus.req = 3'b100;
    step(2);
    rst = 1'b0;
    step(1);
    chk_out("early_gnt", 3'b100, 8'hC3, 1'b1);
    step(1);
    chk_out("early_hold", 3'b100, 8'hC3, 1'b1);
    bus.req = 3'b001;
    step(1);
    chk_out("early_gap", 3'b000, 8'h00, 1'b0);
    step(1);
    chk_out("early_idle", 3'b000, 8'h00, 1'b0);
    step(1);
    chk_out("early_next", 3'b001, 8'h11, 1'b1);

    // req[0] rises one cycle after owner 2 is granted
    rst = 1'b1;
    bus.req = 3'b100;
    step(2);
    rst = 1'b0;
    step(1);
    chk_out("prio_gnt", 3'b100, 8'hC3, 1'b1);
    bus.req = 3'b101;
`ifdef LED_ARB_PRIORITY_EN
    step(1);
    chk_out("prio_gap", 3'b000, 8'h00, 1'b0);
    step(1);
    chk_out("prio_idle", 3'b000, 8'h00, 1'b0);
`else
    hold_then_gap("prio", 3'b100, 8'hC3, 7, 1'b1);
`endif
    step(1);
    chk_out("prio_next", 3'b001, 8'h11, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
